cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles to wait for mem_ack before aborting.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-005 cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
REQ-006 cpu_addr  in  16  CPU byte address.
REQ-007 cpu_wdata  in  8  CPU write data.
REQ-008 cpu_rdata  out  8  read data; valid while cpu_ack=1.
REQ-009 cpu_ack  out  1  one-cycle completion pulse.
REQ-010 cpu_err  out  1  one-cycle pulse with cpu_ack when the memory timed out.
REQ-011 cache_addr  out  16  address presented to the 128-byte direct-mapped cache.
REQ-012 cache_w_rd  out  1  1 = cache write (fill or update), 0 = cache lookup.
REQ-013 cache_wdata  out  8  cache fill/update data.
REQ-014 cache_rdata  in  8  cache read data.
REQ-015 cache_hit  in  1  cache hit flag; valid one cycle after the lookup address is presented.
REQ-016 mem_req  out  1  main-memory request, held until mem_ack.
REQ-017 mem_we  out  1  main-memory write strobe qualifier.
REQ-018 mem_addr  out  16  main-memory address.
REQ-019 mem_wdata  out  8  main-memory write data.
REQ-020 mem_rdata  in  8  main-memory read data; valid with mem_ack.
REQ-021 mem_ack  in  1  main-memory completion, one cycle.

Function
REQ-022 The block SHALL implement the states IDLE, LOOKUP, CHECK, MEM_RD, MEM_WR, FILL and DONE.
REQ-023 In IDLE with cpu_req=1, the block SHALL latch cpu_addr, cpu_we and cpu_wdata, then go to MEM_WR if cpu_we=1, else to LOOKUP.
REQ-024 In LOOKUP, the block SHALL drive cache_addr=latched address and cache_w_rd=0 for one cycle, then go to CHECK.
REQ-025 In CHECK, on cache_hit=1 the block SHALL capture cache_rdata and go to DONE; on cache_hit=0 it SHALL go to MEM_RD.
REQ-026 In MEM_RD, the block SHALL assert mem_req=1, mem_we=0 and mem_addr=latched address until mem_ack; on mem_ack it SHALL capture mem_rdata and go to FILL.
REQ-027 In MEM_WR, the block SHALL assert mem_req=1, mem_we=1 and mem_wdata=latched data until mem_ack, then go to FILL; writes are write-through and write-allocate.
REQ-028 In FILL, the block SHALL drive cache_w_rd=1 for exactly one cycle with cache_addr=latched address and cache_wdata=captured data (read) or latched data (write), then go to DONE.
REQ-029 In DONE, the block SHALL pulse cpu_ack for one cycle with cpu_rdata=captured data (read) or 0x00 (write), then return to IDLE.
REQ-030 Read-hit latency SHALL be exactly 3 cycles from the cpu_req sample edge to cpu_ack.
REQ-031 Read-miss latency SHALL be 5 cycles plus the memory wait time.
REQ-032 A new request SHALL NOT be accepted in the DONE cycle; the earliest next acceptance is the cycle after cpu_ack.
REQ-033 A per-access wait counter SHALL increment each cycle in MEM_RD or MEM_WR; if it reaches TIMEOUT without mem_ack, the block SHALL drop mem_req, skip FILL, and go to DONE with cpu_err=1 and cpu_rdata=0x00.
REQ-034 mem_ack received outside MEM_RD/MEM_WR SHALL be ignored.
REQ-035 Deassertion of cpu_req after acceptance SHALL NOT abort the access.
REQ-036 cache_w_rd SHALL be 0 in every state except FILL, and mem_req SHALL be 0 outside MEM_RD/MEM_WR.

Reset
REQ-037 While rst=1, the block SHALL hold state=IDLE with cpu_ack=0, cpu_err=0, cpu_rdata=0x00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cache_w_rd=0, cache_addr=0, cache_wdata=0 and the wait counter at 0.
REQ-038 Reset asserted mid-access SHALL drop mem_req and cache_w_rd immediately (asynchronously), and the access SHALL NOT be acknowledged.

Configuration
REQ-039 With CACHE_CTRL_STATS_EN defined, the block SHALL add outputs hit_cnt[15:0] and miss_cnt[15:0].
REQ-040 The counters SHALL increment on CHECK hit and CHECK miss respectively, saturate at 0xFFFF, and reset to 0.
REQ-041 Without CACHE_CTRL_STATS_EN, these ports and counters SHALL NOT exist.

Verification
REQ-042 Read hit: preload cache tag/data at 0x0005=0xA9, then read 0x0005 -> cpu_ack 3 cycles after request, cpu_rdata=0xA9, mem_req never asserted.
REQ-043 Read miss: read 0x1234 with memory returning 0x5A after 4 wait cycles -> one FILL with cache_w_rd=1, cache_wdata=0x5A, cpu_rdata=0x5A; a re-read hits in 3 cycles.
REQ-044 Write: write 0x00C0=0x77 -> mem_we=1 with mem_wdata=0x77, then FILL to address 0x00C0; a subsequent read returns 0x77 with no memory access.
REQ-045 Timeout: TIMEOUT=8 with mem_ack never asserted -> mem_req drops after 8 cycles, cpu_ack=1 with cpu_err=1 and cpu_rdata=0x00, and no FILL.
REQ-046 Reset mid-MEM_RD: rst pulsed -> mem_req=0 immediately, no cpu_ack, and the next request is served normally.
REQ-047 With CACHE_CTRL_STATS_EN: 2 hits and 1 miss -> hit_cnt=2, miss_cnt=1.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: CPU-side controller for a 128-byte direct-mapped cache in front of
// a handshaked main memory. Reads look up the cache and, on a miss, fetch the
// byte from memory and fill the cache. Writes are write-through and
// write-allocate: memory first, then a cache fill. A per-access wait counter
// aborts memory accesses that exceed TIMEOUT cycles.
// Optional feature: define CACHE_CTRL_STATS_EN to add the hit_cnt/miss_cnt
// statistics outputs.
module cache_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [15:0] cache_addr,
    output logic        cache_w_rd,
    output logic [7:0]  cache_wdata,
    input  logic [7:0]  cache_rdata,
    input  logic        cache_hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        CHECK  = 3'd2,
        MEM_RD = 3'd3,
        MEM_WR = 3'd4,
        FILL   = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    // Latched request and captured data
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_data;
    logic [WAIT_W-1:0]   r_wait;
    logic [ADDR_W-1:0]   w_addr_nx;
    logic                w_we_nx;
    logic [DATA_W-1:0]   w_wdata_nx;
    logic [DATA_W-1:0]   w_data_nx;
    logic [WAIT_W-1:0]   w_wait_nx;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic                w_timeout;

    // Registered outputs and their next values
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic                r_cpu_ack;
    logic                r_cpu_err;
    logic [ADDR_W-1:0]   r_cache_addr;
    logic                r_cache_w_rd;
    logic [DATA_W-1:0]   r_cache_wdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   w_cpu_rdata_nx;
    logic                w_cpu_ack_nx;
    logic [ADDR_W-1:0]   w_cache_addr_nx;
    logic                w_cache_w_rd_nx;
    logic [DATA_W-1:0]   w_cache_wdata_nx;
    logic                w_mem_req_nx;
    logic                w_mem_we_nx;
    logic [ADDR_W-1:0]   w_mem_addr_nx;
    logic [DATA_W-1:0]   w_mem_wdata_nx;

    assign w_wait_inc = r_wait + WAIT_W'(1);

    // Next-state, latch/capture and next-output logic
    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_we_nx    = r_we;
        w_wdata_nx = r_wdata;
        w_data_nx  = r_data;
        w_wait_nx  = r_wait;
        w_timeout  = 1'b0;

        case (r_state)
            IDLE: begin
                w_wait_nx = '0;
                if (cpu_req) begin
                    w_addr_nx  = cpu_addr;
                    w_we_nx    = cpu_we;
                    w_wdata_nx = cpu_wdata;
                    w_data_nx  = '0;
                    w_state_nx = cpu_we ? MEM_WR : LOOKUP;
                end
            end
            LOOKUP: w_state_nx = CHECK;
            CHECK: begin
                if (cache_hit) begin
                    w_data_nx  = cache_rdata;
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = MEM_RD;
                end
            end
            MEM_RD, MEM_WR: begin
                w_wait_nx = w_wait_inc;
                if (mem_ack) begin
                    // Fill data: fetched byte on a read, the CPU byte on a write
                    w_data_nx  = (r_state == MEM_RD) ? mem_rdata : r_wdata;
                    w_state_nx = FILL;
                end else if (w_wait_inc == WAIT_W'(TIMEOUT)) begin
                    w_timeout  = 1'b1;
                    w_state_nx = DONE;
                end
            end
            FILL: w_state_nx = DONE;
            DONE: w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase

        w_cache_w_rd_nx  = (w_state_nx == FILL);
        w_cache_addr_nx  = r_cache_addr;
        w_cache_wdata_nx = r_cache_wdata;
        if (w_state_nx == LOOKUP || w_state_nx == FILL) begin
            w_cache_addr_nx = w_addr_nx;
        end
        if (w_state_nx == FILL) begin
            w_cache_wdata_nx = w_data_nx;
        end

        w_mem_req_nx   = (w_state_nx == MEM_RD) || (w_state_nx == MEM_WR);
        w_mem_we_nx    = (w_state_nx == MEM_WR);
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        if (w_mem_req_nx) begin
            w_mem_addr_nx = w_addr_nx;
        end
        if (w_state_nx == MEM_WR) begin
            w_mem_wdata_nx = w_wdata_nx;
        end

        w_cpu_ack_nx   = (w_state_nx == DONE);
        w_cpu_rdata_nx = '0;
        if (w_state_nx == DONE && !w_we_nx && !w_timeout) begin
            w_cpu_rdata_nx = w_data_nx;
        end
    end

    // State, request context and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_data        <= '0;
            r_wait        <= '0;
            r_cpu_rdata   <= '0;
            r_cpu_ack     <= 1'b0;
            r_cpu_err     <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_w_rd  <= 1'b0;
            r_cache_wdata <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_addr        <= w_addr_nx;
            r_we          <= w_we_nx;
            r_wdata       <= w_wdata_nx;
            r_data        <= w_data_nx;
            r_wait        <= w_wait_nx;
            r_cpu_rdata   <= w_cpu_rdata_nx;
            r_cpu_ack     <= w_cpu_ack_nx;
            r_cpu_err     <= w_timeout;
            r_cache_addr  <= w_cache_addr_nx;
            r_cache_w_rd  <= w_cache_w_rd_nx;
            r_cache_wdata <= w_cache_wdata_nx;
            r_mem_req     <= w_mem_req_nx;
            r_mem_we      <= w_mem_we_nx;
            r_mem_addr    <= w_mem_addr_nx;
            r_mem_wdata   <= w_mem_wdata_nx;
        end
    end

    assign cpu_rdata   = r_cpu_rdata;
    assign cpu_ack     = r_cpu_ack;
    assign cpu_err     = r_cpu_err;
    assign cache_addr  = r_cache_addr;
    assign cache_w_rd  = r_cache_w_rd;
    assign cache_wdata = r_cache_wdata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating hit/miss counters, updated on the CHECK decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == CHECK) begin
            if (cache_hit && r_hit_cnt != 16'hFFFF) begin
                r_hit_cnt <= r_hit_cnt + 16'(1);
            end
            if (!cache_hit && r_miss_cnt != 16'hFFFF) begin
                r_miss_cnt <= r_miss_cnt + 16'(1);
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
